// File: rtl/paralelo_serie_pkg.sv
// Shared serial-link definitions used by both the transmitter and receiver.
package paralelo_serie_pkg;

  localparam int WORD_W    = 8;
  localparam int BIT_IDX_W = 3;

  // Comma symbol used for alignment bursts and for idle line fill.
  localparam logic [WORD_W-1:0] COMMA_BC = 8'hBC;

  typedef logic [BIT_IDX_W-1:0] bit_idx_t;

endpackage

// File: rtl/paralelo_serie.sv
// Parallel-to-serial transmitter: MSB-first, one bit per clk_32f cycle.
// Emits a burst of comma words after reset, then sends offered words and
// fills empty word slots with the idle symbol.
module paralelo_serie
  import paralelo_serie_pkg::*;
#(
  parameter int                SYNC_WORDS = 4,
  parameter logic [WORD_W-1:0] IDLE_WORD  = COMMA_BC
) (
  input  logic                 clk_32f,
  input  logic                 reset,
  input  logic [WORD_W-1:0]    data_in,
  input  logic                 valid_in,
  output logic                 load_req,
  output logic                 data_out,
  output logic                 valid_out,
  output logic                 word_start,
  output logic                 sync_done,
  output logic [BIT_IDX_W-1:0] bit_cnt
);

  // sync_cnt counts comma words already started; it saturates at SYNC_WORDS.
  localparam int                SC_W      = $clog2(SYNC_WORDS + 1);
  localparam logic [SC_W-1:0]   SYNC_LAST = SC_W'(SYNC_WORDS);
  localparam logic [SC_W-1:0]   SYNC_ONE  = SC_W'(1);
  localparam bit_idx_t          LAST_BIT  = bit_idx_t'(WORD_W - 1);

  logic [WORD_W-1:0] sr;
  logic [SC_W-1:0]   sync_cnt;
  logic              vreg;

  // All outputs decode registered state only; no input reaches an output.
  assign data_out   = sr[WORD_W-1];
  assign valid_out  = vreg;
  assign word_start = (bit_cnt == '0);
  assign sync_done  = (sync_cnt == SYNC_LAST);
  assign load_req   = (bit_cnt == LAST_BIT) && sync_done;

  // Shift one bit per cycle; at the word boundary reload with a comma
  // (during sync or when nothing is offered) or with the offered word.
  always_ff @(posedge clk_32f) begin
    if (reset) begin
      sr       <= IDLE_WORD;
      bit_cnt  <= '0;
      sync_cnt <= SYNC_ONE;
      vreg     <= 1'b0;
    end else if (bit_cnt != LAST_BIT) begin
      sr      <= {sr[WORD_W-2:0], 1'b0};
      bit_cnt <= bit_cnt + bit_idx_t'(1);
    end else begin
      bit_cnt <= '0;
      if (!sync_done) begin
        sr       <= IDLE_WORD;
        vreg     <= 1'b0;
        sync_cnt <= sync_cnt + SYNC_ONE;
      end else if (valid_in) begin
        sr   <= data_in;
        vreg <= 1'b1;
      end else begin
        sr   <= IDLE_WORD;
        vreg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_paralelo_serie.sv
// Self-checking bench for paralelo_serie with a word-level reference model.
module tb_paralelo_serie;

  localparam int SYNC_WORDS = 4;

  logic       clk_32f  = 1'b0;
  logic       reset    = 1'b1;
  logic [7:0] data_in  = 8'h00;
  logic       valid_in = 1'b0;
  logic       load_req;
  logic       data_out;
  logic       valid_out;
  logic       word_start;
  logic       sync_done;
  logic [2:0] bit_cnt;

  always #5 clk_32f = ~clk_32f;

  paralelo_serie #(.SYNC_WORDS(SYNC_WORDS), .IDLE_WORD(8'hBC)) dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .load_req  (load_req),
    .data_out  (data_out),
    .valid_out (valid_out),
    .word_start(word_start),
    .sync_done (sync_done),
    .bit_cnt   (bit_cnt)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: cycle number since reset and the word occupying the line.
  int         t        = 0;
  bit         model_ok = 1'b0;
  logic [7:0] cur_word = 8'hBC;
  bit         cur_valid = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, t);
    end
  endtask

  // Word slot k (cycles 8k..8k+7) is a comma for k < SYNC_WORDS; later slots
  // carry whatever was offered at the edge ending cycle 8k-1, else a comma.
  always @(posedge clk_32f) begin
    if (reset) begin
      t         = 0;
      cur_word  = 8'hBC;
      cur_valid = 1'b0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      if (t % 8 == 7) begin
        if ((t + 1) / 8 < SYNC_WORDS || !valid_in) begin
          cur_word  = 8'hBC;
          cur_valid = 1'b0;
        end else begin
          cur_word  = data_in;
          cur_valid = 1'b1;
        end
      end
      t = t + 1;
    end
  end

  logic [7:0]  acc        = 8'h00;
  logic [7:0]  last_byte  = 8'h00;
  logic [23:0] hist       = 24'h0;
  int          sd_rise    = -1;
  int          first_load = -1;

  // Compare every cycle on the falling edge and collect received bytes.
  always @(negedge clk_32f) begin
    if (model_ok) begin
      chk("data_out",   data_out,   cur_word[7 - (t % 8)]);
      chk("valid_out",  valid_out,  cur_valid);
      chk("word_start", word_start, t % 8 == 0);
      chk("bit_cnt",    bit_cnt,    t % 8);
      chk("sync_done",  sync_done,  t >= 8 * (SYNC_WORDS - 1));
      chk("load_req",   load_req,   (t % 8 == 7) && (t >= 8 * SYNC_WORDS - 1));
      acc = {acc[6:0], data_out};
      if (t % 8 == 7) begin
        last_byte = acc;
        hist      = {hist[15:0], acc};
      end
      if (sync_done && sd_rise < 0) sd_rise = t;
      if (load_req && first_load < 0) first_load = t;
    end
  end

  task automatic step();
    @(posedge clk_32f);
    #1;
  endtask

  task automatic wait_t(input int n);
    for (int k = 0; k < 300; k++) begin
      if (t == n) return;
      step();
    end
    chk("wait_cycle_timeout", 32'(t), 32'(n));
  endtask

  task automatic wait_load();
    for (int k = 0; k < 300; k++) begin
      if ((t % 8 == 7) && (t >= 8 * SYNC_WORDS - 1)) return;
      step();
    end
    chk("wait_load_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    step();
    repeat (3) step();
    reset = 1'b0;

    // Sync burst, then 0xA5 at the first load slot.
    wait_t(31);
    data_in  = 8'hA5;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    data_in  = 8'h00;
    chk("t1_sync_rise",  32'(sd_rise),    32'd24);
    chk("t1_first_load", 32'(first_load), 32'd31);
    chk("t1_word3",      last_byte,       8'hBC);
    wait_t(40);
    chk("t2_word_a5",    last_byte,       8'hA5);

    // Back-to-back words with no gap.
    wait_load();
    data_in  = 8'h00;
    valid_in = 1'b1;
    step();
    wait_load();
    data_in = 8'hFF;
    step();
    wait_load();
    data_in = 8'h3C;
    step();
    valid_in = 1'b0;
    repeat (8) step();
    chk("t3_stream", hist, 24'h00FF3C);

    // Offered data during sync is ignored until the first load slot.
    reset    = 1'b1;
    data_in  = 8'h55;
    valid_in = 1'b1;
    step();
    reset = 1'b0;
    wait_t(32);
    chk("t4_sync_word", last_byte, 8'hBC);
    wait_t(40);
    chk("t4_word_55",   last_byte, 8'h55);
    valid_in = 1'b0;

    // Reset in the middle of a data word.
    wait_load();
    data_in  = 8'hC3;
    valid_in = 1'b1;
    step();
    valid_in = 1'b0;
    repeat (3) step();
    chk("t5_pre_bit", bit_cnt, 3'd3);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("t5_bit_cnt",  bit_cnt,      3'd0);
    chk("t5_data_out", data_out,     1'b1);
    chk("t5_valid",    valid_out,    1'b0);
    chk("t5_sync_cnt", dut.sync_cnt, 3'd1);
    wait_t(32);
    chk("t5_burst",    last_byte,    8'hBC);

    // Randomised traffic; inputs change every cycle, only load slots matter.
    for (int i = 0; i < 600; i++) begin
      valid_in = ($urandom_range(0, 3) != 0);
      data_in  = 8'($urandom);
      step();
    end
    valid_in = 1'b0;
    repeat (8) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

endmodule
